wb_stage: RTL and testbench

//  Write-back stage, directly downstream of the memory stage; consumes the MEM latch fields.

---
 rtl/wb_stage_pkg.sv | 35 +++
 rtl/wb_stage_if.sv | 33 +++
 rtl/wb_retire_fsm.sv | 68 ++++++
 rtl/wb_stage.sv | 91 +++++++++
 tb/tb_wb_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: widths, canary value,
// WB state encodings and the MEM-latch field layout shared with mem_stage packing.
package wb_stage_pkg;

    localparam int DBITS     = 32;
    localparam int INSTBITS  = 32;
    localparam int REGNOBITS = 5;
    localparam int CANARY_W  = 4;

    localparam logic [CANARY_W-1:0] CANARY_VAL = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_ERROR  = 2'd2
    } wb_state_e;

    // MEM-latch field order, most significant field first
    typedef struct packed {
        logic                  valid;
        logic [INSTBITS-1:0]   inst;
        logic [DBITS-1:0]      pc;
        logic [DBITS-1:0]      inst_count;
        logic                  wr_reg;
        logic [REGNOBITS-1:0]  rd;
        logic [DBITS-1:0]      rd_val;
        logic                  is_halt;
        logic [CANARY_W-1:0]   canary;
    } mem_latch_t;

    function automatic logic canary_ok(input logic [CANARY_W-1:0] canary);
        return canary == CANARY_VAL;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM-latch to WB bus plus the regfile write / forwarding return path.
// master = memory-stage side, slave = write-back stage.
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic                  mem_valid;
    logic [INSTBITS-1:0]   mem_inst;
    logic [DBITS-1:0]      mem_pc;
    logic [DBITS-1:0]      mem_inst_count;
    logic                  mem_wr_reg;
    logic [REGNOBITS-1:0]  mem_rd;
    logic [DBITS-1:0]      mem_rd_val;
    logic                  mem_is_halt;
    logic [CANARY_W-1:0]   mem_canary;

    logic                  wb_reg_we;
    logic [REGNOBITS-1:0]  wb_rd;
    logic [DBITS-1:0]      wb_rd_val;
    logic [REGNOBITS-1:0]  wb_busy_rd;

    modport master (
        output mem_valid, mem_inst, mem_pc, mem_inst_count, mem_wr_reg,
               mem_rd, mem_rd_val, mem_is_halt, mem_canary,
        input  wb_reg_we, wb_rd, wb_rd_val, wb_busy_rd
    );

    modport slave (
        input  mem_valid, mem_inst, mem_pc, mem_inst_count, mem_wr_reg,
               mem_rd, mem_rd_val, mem_is_halt, mem_canary,
        output wb_reg_we, wb_rd, wb_rd_val, wb_busy_rd
    );

endinterface

// File: rtl/wb_retire_fsm.sv
// Retire/halt/error state machine: fault checks, expected fetch count,
// retired-instruction counter.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_RUN    | normal operation, valid clean entries retire
//  ST_HALTED | HALT retired; architectural updates frozen
//  ST_ERROR  | canary or ordering fault seen; updates frozen until reset
module wb_retire_fsm
    import wb_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_valid,
    input  logic [DBITS-1:0]     mem_inst_count,
    input  logic                 mem_is_halt,
    input  logic [CANARY_W-1:0]  mem_canary,
    output logic                 retire,
    output logic [DBITS-1:0]     retired_cnt,
    output logic                 halted,
    output logic                 err
);

    wb_state_e         state_q;
    wb_state_e         state_d;
    logic [DBITS-1:0]  expected_count;
    logic              fault;
    logic              live;

    // Fault detection, retire qualification and next-state selection
    always_comb begin
        state_d = state_q;
        live    = !reset && mem_valid && (state_q == ST_RUN);
        fault   = live && (!canary_ok(mem_canary) || (mem_inst_count != expected_count));
        retire  = live && !fault;
        unique case (state_q)
            ST_RUN: begin
                if (fault)
                    state_d = ST_ERROR;
                else if (retire && mem_is_halt)
                    state_d = ST_HALTED;
            end
            ST_HALTED: state_d = ST_HALTED;
            ST_ERROR:  state_d = ST_ERROR;
            // an unused encoding can only come from corruption
            default:   state_d = ST_ERROR;
        endcase
    end

    // State, expected sequence number and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            expected_count <= '0;
            retired_cnt    <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_cnt    <= retired_cnt + DBITS'(1);
                expected_count <= mem_inst_count + DBITS'(1);
            end
        end
    end

    assign halted = (state_q == ST_HALTED);
    assign err    = (state_q == ST_ERROR);

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: regfile write port and forwarding bus (combinational from
// the MEM latch), last retired PC, and optional retire trace.
// Optional feature macro: WB_TRACE_EN (trace ports and per-retire print).
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    wb_stage_if.slave             bus,
    output logic [DBITS-1:0]      retired_cnt,
    output logic [DBITS-1:0]      last_pc,
    output logic                  halted,
    output logic                  err
`ifdef WB_TRACE_EN
    ,
    output logic                  trace_valid,
    output logic [DBITS-1:0]      trace_pc,
    output logic [INSTBITS-1:0]   trace_inst,
    output logic [REGNOBITS-1:0]  trace_rd,
    output logic [DBITS-1:0]      trace_val
`endif
);

    logic retire;
    logic reg_we;

    wb_retire_fsm u_fsm (
        .clk            (clk),
        .reset          (reset),
        .mem_valid      (bus.mem_valid),
        .mem_inst_count (bus.mem_inst_count),
        .mem_is_halt    (bus.mem_is_halt),
        .mem_canary     (bus.mem_canary),
        .retire         (retire),
        .retired_cnt    (retired_cnt),
        .halted         (halted),
        .err            (err)
    );

    // Regfile write and forward bus: same-cycle, x0 writes dropped
    always_comb begin
        reg_we         = retire && bus.mem_wr_reg && (bus.mem_rd != '0);
        bus.wb_reg_we  = reg_we;
        bus.wb_rd      = reg_we ? bus.mem_rd     : '0;
        bus.wb_rd_val  = reg_we ? bus.mem_rd_val : '0;
        bus.wb_busy_rd = reg_we ? bus.mem_rd     : '0;
    end

    // PC of the most recently retired instruction
    always_ff @(posedge clk) begin
        if (reset)
            last_pc <= '0;
        else if (retire)
            last_pc <= bus.mem_pc;
    end

`ifdef WB_TRACE_EN
    // Retire trace, one cycle behind the retire
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_inst  <= '0;
            trace_rd    <= '0;
            trace_val   <= '0;
        end else begin
            trace_valid <= retire;
            if (retire) begin
                trace_pc   <= bus.mem_pc;
                trace_inst <= bus.mem_inst;
                trace_rd   <= bus.mem_rd;
                trace_val  <= bus.mem_rd_val;
            end
        end
    end

`ifndef SYNTHESIS
    // Human-readable retire log
    always @(posedge clk) begin
        if (retire)
            $display("WB %0d pc=%h rd=%0d val=%h",
                     retired_cnt + DBITS'(1), bus.mem_pc, bus.mem_rd, bus.mem_rd_val);
    end
`endif
`else
    // instruction word is only consumed by the trace
    logic unused_inst;
    assign unused_inst = ^bus.mem_inst;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected regfile writes,
// a negedge monitor pops and compares whenever wb_reg_we is seen.
module tb_wb_stage;
    import wb_stage_pkg::*;

    typedef struct packed {
        logic [REGNOBITS-1:0] rd;
        logic [DBITS-1:0]     val;
    } wr_t;

    logic clk;
    logic reset;
    logic [DBITS-1:0] retired_cnt;
    logic [DBITS-1:0] last_pc;
    logic halted;
    logic err;
`ifdef WB_TRACE_EN
    logic                 trace_valid;
    logic [DBITS-1:0]     trace_pc;
    logic [INSTBITS-1:0]  trace_inst;
    logic [REGNOBITS-1:0] trace_rd;
    logic [DBITS-1:0]     trace_val;
`endif

    int checks   = 0;
    int failures = 0;
    wr_t exp_q[$];

    wb_stage_if bus ();

    wb_stage dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .retired_cnt (retired_cnt),
        .last_pc     (last_pc),
        .halted      (halted),
        .err         (err)
`ifdef WB_TRACE_EN
        ,
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_inst  (trace_inst),
        .trace_rd    (trace_rd),
        .trace_val   (trace_val)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every write must match the head of the expected queue
    always @(negedge clk) begin
        if (bus.wb_reg_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write got rd=%0d val=0x%0h exp=no write",
                         bus.wb_rd, bus.wb_rd_val);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_rd", 32'(bus.wb_rd), 32'(e.rd));
                chk("wr_val", bus.wb_rd_val, e.val);
                chk("busy_rd", 32'(bus.wb_busy_rd), 32'(e.rd));
            end
        end else begin
            chk("busy_rd_idle", 32'(bus.wb_busy_rd), 32'd0);
        end
    end

    task automatic idle_bus();
        bus.mem_valid      = 1'b0;
        bus.mem_inst       = '0;
        bus.mem_pc         = '0;
        bus.mem_inst_count = '0;
        bus.mem_wr_reg     = 1'b0;
        bus.mem_rd         = '0;
        bus.mem_rd_val     = '0;
        bus.mem_is_halt    = 1'b0;
        bus.mem_canary     = CANARY_VAL;
    endtask

    // Present one MEM-latch entry for one cycle
    task automatic issue(input logic v, input logic [31:0] cnt, input logic [31:0] pc,
                         input logic wr, input logic [4:0] rd, input logic [31:0] val,
                         input logic halt, input logic [3:0] can, input logic exp_wr);
        bus.mem_valid      = v;
        bus.mem_inst       = 32'h0000_0013 ^ pc;
        bus.mem_pc         = pc;
        bus.mem_inst_count = cnt;
        bus.mem_wr_reg     = wr;
        bus.mem_rd         = rd;
        bus.mem_rd_val     = val;
        bus.mem_is_halt    = halt;
        bus.mem_canary     = can;
        if (exp_wr) exp_q.push_back({rd, val});
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic status(input string tag, input logic [31:0] cnt, input logic [31:0] pc,
                          input logic h, input logic e);
        chk({tag, "_cnt"}, retired_cnt, cnt);
        chk({tag, "_pc"}, last_pc, pc);
        chk({tag, "_halted"}, 32'(halted), 32'(h));
        chk({tag, "_err"}, 32'(err), 32'(e));
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle_bus();
        @(posedge clk);
        #1;
        do_reset();
        status("reset", 0, 0, 0, 0);

        // 1: three adds
        issue(1, 0, 32'h100, 1, 1, 32'h10, 0, 4'hF, 1);
        issue(1, 1, 32'h104, 1, 2, 32'h20, 0, 4'hF, 1);
        issue(1, 2, 32'h108, 1, 3, 32'h30, 0, 4'hF, 1);
        status("t1", 3, 32'h108, 0, 0);

        // 2: write to x0 dropped but retires
        issue(1, 3, 32'h10C, 1, 0, 32'hDEAD, 0, 4'hF, 0);
        status("t2", 4, 32'h10C, 0, 0);

        // 3: bubbles are never checked and never write
        do_reset();
        issue(1, 0, 32'h200, 1, 4, 32'h44, 0, 4'hF, 1);
        issue(0, 7, 32'h204, 1, 9, 32'h99, 0, 4'h0, 0);
        issue(0, 9, 32'h208, 1, 9, 32'h99, 1, 4'h3, 0);
        issue(1, 1, 32'h20C, 1, 6, 32'h66, 0, 4'hF, 1);
        status("t3", 2, 32'h20C, 0, 0);

        // 4: HALT at count 4 writes rd5, then freezes
        do_reset();
        for (int i = 0; i < 4; i++)
            issue(1, i, 32'h300 + 4 * i, 1, 5'd8, 32'(i), 0, 4'hF, 1);
        issue(1, 4, 32'h310, 1, 5, 32'h7, 1, 4'hF, 1);
        status("t4_halt", 5, 32'h310, 1, 0);
        issue(1, 5, 32'h314, 1, 9, 32'h55, 0, 4'hF, 0);
        issue(1, 6, 32'h318, 1, 10, 32'h66, 0, 4'hF, 0);
        status("t4_frozen", 5, 32'h310, 1, 0);

        // 5: bad canary at count 2
        do_reset();
        issue(1, 0, 32'h400, 1, 1, 32'h1, 0, 4'hF, 1);
        issue(1, 1, 32'h404, 1, 2, 32'h2, 0, 4'hF, 1);
        issue(1, 2, 32'h408, 1, 3, 32'h3, 0, 4'h0, 0);
        status("t5_err", 2, 32'h404, 0, 1);
        issue(1, 3, 32'h40C, 1, 4, 32'h4, 0, 4'hF, 0);
        status("t5_frozen", 2, 32'h404, 0, 1);

        // 6: ordering fault, reset mid-stream, restart at 0
        do_reset();
        issue(1, 0, 32'h500, 1, 1, 32'h1, 0, 4'hF, 1);
        issue(1, 1, 32'h504, 1, 2, 32'h2, 0, 4'hF, 1);
        issue(1, 3, 32'h50C, 1, 3, 32'h3, 0, 4'hF, 0);
        status("t6_err", 2, 32'h504, 0, 1);
        bus.mem_valid = 1'b1; bus.mem_inst_count = 0; bus.mem_wr_reg = 1'b1;
        bus.mem_rd = 5'd7; bus.mem_rd_val = 32'h77; bus.mem_pc = 32'h510;
        do_reset();
        idle_bus();
        status("t6_reset", 0, 0, 0, 0);
        issue(1, 0, 32'h600, 1, 11, 32'hAB, 0, 4'hF, 1);
        status("t6_resume", 1, 32'h600, 0, 0);

        // 7: halt with double fault -> error wins, no retire
        do_reset();
        issue(1, 0, 32'h700, 1, 1, 32'h1, 0, 4'hF, 1);
        issue(1, 5, 32'h704, 1, 3, 32'h3, 1, 4'h0, 0);
        status("t7", 1, 32'h700, 0, 1);

        @(negedge clk);
        chk("final_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
